dr_file: RTL and testbench

- Parametrised successor to the single 8-bit data register: a bank of DEPTH data registers, WIDTH bits each.
- Each write can perform an in-place register operation: load, increment, decrement, shift or rotate.
- Provides two registered read ports and carry/zero flags.
- Provides a multi-cycle clear-all sweep with a busy/error handshake.
- Sits between the internal data bus and the ALU/control unit.

---
 rtl/dr_file.sv | 134 +++++++++++++
 tb/tb_dr_file.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/dr_file.sv
// Bank of DEPTH data registers with in-place load/inc/dec/shift/rotate ops,
// two registered read ports with write-first bypass, carry/zero flags and a clear-all sweep.
module dr_file #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [2:0]       op,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             cin,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    output logic             carry,
    output logic             zero,
    output logic             busy,
    output logic             err
);
    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_INC  = 3'd1;
    localparam logic [2:0] OP_DEC  = 3'd2;
    localparam logic [2:0] OP_SHL  = 3'd3;
    localparam logic [2:0] OP_SHR  = 3'd4;
    localparam logic [2:0] OP_ROL  = 3'd5;
    localparam logic [2:0] OP_ROR  = 3'd6;
    localparam logic [2:0] OP_CLR  = 3'd7;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t           state_q;
    logic [AW-1:0]    idx_q;
    logic             busy_q, err_q, carry_q, zero_q;
    logic [WIDTH-1:0] rdata_a_q, rdata_b_q;
    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [WIDTH-1:0] rdata_a_d, rdata_b_d;

    logic [WIDTH-1:0] cur, res;
    logic             res_c, in_range, is_clr, accept, start, reject, last;

    always_comb begin
        cur = '0;
        for (int i = 0; i < DEPTH; i++)
            if (int'(waddr) == i) cur = regs_q[i];

        in_range = int'(waddr) < DEPTH;
        is_clr   = (op == OP_CLR);
        accept   = we && (state_q == IDLE) && !is_clr && in_range;
        start    = we && (state_q == IDLE) && is_clr;
        reject   = we && ((state_q == SWEEP) || (!is_clr && !in_range));
        last     = int'(idx_q) == DEPTH - 1;

        res   = cur;
        res_c = 1'b0;
        case (op)
            OP_LOAD: begin res = wdata; res_c = 1'b0; end
            OP_INC:  {res_c, res} = {1'b0, cur} + (WIDTH+1)'(1);
            OP_DEC:  begin res = cur - WIDTH'(1); res_c = (cur == '0); end
            OP_SHL:  begin res = {cur[WIDTH-2:0], cin}; res_c = cur[WIDTH-1]; end
            OP_SHR:  begin res = {cin, cur[WIDTH-1:1]}; res_c = cur[0]; end
            OP_ROL:  begin res = {cur[WIDTH-2:0], cur[WIDTH-1]}; res_c = cur[WIDTH-1]; end
            OP_ROR:  begin res = {cur[0], cur[WIDTH-1:1]}; res_c = cur[0]; end
            default: begin res = cur; res_c = 1'b0; end
        endcase

        regs_d = regs_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (accept && int'(waddr) == i) regs_d[i] = res;
            if (state_q == SWEEP && int'(idx_q) == i) regs_d[i] = '0;
        end

        // Reading from next-state values gives write-first bypass for free.
        rdata_a_d = '0;
        rdata_b_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (int'(raddr_a) == i) rdata_a_d = regs_d[i];
            if (int'(raddr_b) == i) rdata_b_d = regs_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            rdata_a_q <= '0;
            rdata_b_q <= '0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b1;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            idx_q     <= '0;
            state_q   <= IDLE;
        end else begin
            regs_q    <= regs_d;
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
            err_q     <= reject;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= SWEEP;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                    if (accept) begin
                        carry_q <= res_c;
                        zero_q  <= (res == '0);
                    end
                end
                SWEEP: begin
                    idx_q <= idx_q + AW'(1);
                    if (last) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        carry_q <= 1'b0;
                        zero_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rdata_a = rdata_a_q;
    assign rdata_b = rdata_b_q;
    assign carry   = carry_q;
    assign zero    = zero_q;
    assign busy    = busy_q;
    assign err     = err_q;
endmodule

// File: tb/tb_dr_file.sv
// Directed bench for dr_file: default 4x8 instance plus a DEPTH=3 instance
// for out-of-range addressing and reset-during-sweep.
module tb_dr_file;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // default instance
    logic       we = 0, cin = 0;
    logic [2:0] op = 0;
    logic [1:0] waddr = 0, raddr_a = 0, raddr_b = 0;
    logic [7:0] wdata = 0, rdata_a, rdata_b;
    logic       carry, zero, busy, err;

    // DEPTH=3 instance
    logic       we3 = 0, cin3 = 0;
    logic [2:0] op3 = 0;
    logic [1:0] waddr3 = 0, raddr_a3 = 0, raddr_b3 = 0;
    logic [7:0] wdata3 = 0, rdata_a3, rdata_b3;
    logic       carry3, zero3, busy3, err3;

    dr_file #(.WIDTH(8), .DEPTH(4), .AW(2)) u_dut (
        .clk(clk), .rst(rst), .we(we), .op(op), .waddr(waddr), .wdata(wdata), .cin(cin),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
        .carry(carry), .zero(zero), .busy(busy), .err(err));

    dr_file #(.WIDTH(8), .DEPTH(3), .AW(2)) u_d3 (
        .clk(clk), .rst(rst), .we(we3), .op(op3), .waddr(waddr3), .wdata(wdata3), .cin(cin3),
        .raddr_a(raddr_a3), .raddr_b(raddr_b3), .rdata_a(rdata_a3), .rdata_b(rdata_b3),
        .carry(carry3), .zero(zero3), .busy(busy3), .err(err3));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one edge; outputs are sampled 1 time unit after it
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [1:0] a, input logic [7:0] d, input logic c);
        we = 1; op = o; waddr = a; wdata = d; cin = c;
        cyc();
        we = 0;
    endtask

    initial begin
        cyc(); cyc();
        chk("rst_rdata_a", rdata_a, 8'h00);
        chk("rst_zero",    zero,    1'b1);
        chk("rst_carry",   carry,   1'b0);
        chk("rst_busy",    busy,    1'b0);
        chk("rst_err",     err,     1'b0);
        rst = 0;

        // reset beats a same-cycle load
        raddr_a = 2;
        issue(3'd0, 2'd2, 8'hA5, 0);
        chk("pre_rst_load", rdata_a, 8'hA5);
        rst = 1; we = 1; op = 3'd0; waddr = 2; wdata = 8'h3C;
        cyc();
        rst = 0; we = 0;
        chk("rst_pri_rdata", rdata_a, 8'h00);
        chk("rst_pri_zero",  zero,    1'b1);
        chk("rst_pri_carry", carry,   1'b0);
        cyc();
        chk("rst_load_dropped", rdata_a, 8'h00);

        // load with same-cycle read bypass; empty entry reads 0
        raddr_a = 1; raddr_b = 3;
        issue(3'd0, 2'd1, 8'h5A, 0);
        chk("bypass_a", rdata_a, 8'h5A);
        chk("empty_b",  rdata_b, 8'h00);
        chk("load_zero", zero, 1'b0);

        // INC/DEC wrap
        raddr_a = 0;
        issue(3'd0, 2'd0, 8'hFF, 0);
        chk("ld_ff", rdata_a, 8'hFF);
        issue(3'd1, 2'd0, 8'h00, 0);
        chk("inc_val",   rdata_a, 8'h00);
        chk("inc_carry", carry,   1'b1);
        chk("inc_zero",  zero,    1'b1);
        issue(3'd2, 2'd0, 8'h00, 0);
        chk("dec_val",   rdata_a, 8'hFF);
        chk("dec_carry", carry,   1'b1);
        chk("dec_zero",  zero,    1'b0);
        issue(3'd2, 2'd0, 8'h00, 0);
        chk("dec2_val",   rdata_a, 8'hFE);
        chk("dec2_carry", carry,   1'b0);

        // shifts and rotates
        raddr_a = 3;
        issue(3'd0, 2'd3, 8'h81, 0);
        issue(3'd3, 2'd3, 8'h00, 0);
        chk("shl_val",   rdata_a, 8'h02);
        chk("shl_carry", carry,   1'b1);
        issue(3'd6, 2'd3, 8'h00, 0);
        chk("ror_val",   rdata_a, 8'h01);
        chk("ror_carry", carry,   1'b0);
        issue(3'd4, 2'd3, 8'h00, 1);
        chk("shr_val",   rdata_a, 8'h80);
        chk("shr_carry", carry,   1'b1);
        issue(3'd5, 2'd3, 8'h00, 0);
        chk("rol_val",   rdata_a, 8'h01);
        chk("rol_carry", carry,   1'b1);
        cyc();
        chk("flag_hold_carry", carry, 1'b1);
        chk("flag_hold_zero",  zero,  1'b0);

        // clear-all sweep
        for (int i = 0; i < 4; i++) issue(3'd0, 2'(i), 8'(8'h11 * (i + 1)), 0);
        raddr_a = 0; raddr_b = 3;
        issue(3'd7, 2'd0, 8'h00, 0);                   // E0
        chk("sw_busy0", busy, 1'b1);
        chk("sw_b_before", rdata_b, 8'h44);
        cyc();                                         // E1 clears reg0
        chk("sw_busy1", busy, 1'b1);
        chk("sw_bypass_a", rdata_a, 8'h00);
        issue(3'd0, 2'd0, 8'h99, 0);                   // E2, rejected
        chk("sw_err",   err,  1'b1);
        chk("sw_busy2", busy, 1'b1);
        chk("sw_zero_hold", zero, 1'b0);
        chk("sw_rej_a", rdata_a, 8'h00);
        cyc();                                         // E3
        chk("sw_err_pulse", err, 1'b0);
        chk("sw_busy3", busy, 1'b1);
        cyc();                                         // E4 clears reg3, done
        chk("sw_done_busy", busy, 1'b0);
        chk("sw_done_zero", zero, 1'b1);
        chk("sw_done_carry", carry, 1'b0);
        chk("sw_bypass_b", rdata_b, 8'h00);
        raddr_a = 1; raddr_b = 2;
        issue(3'd0, 2'd0, 8'h77, 0);                   // accepted as busy is low
        chk("sw_after_a", rdata_a, 8'h00);
        chk("sw_after_b", rdata_b, 8'h00);
        chk("sw_after_err", err, 1'b0);
        raddr_a = 0;
        cyc();
        chk("post_sweep_load", rdata_a, 8'h77);

        // DEPTH=3: out-of-range write and read
        raddr_a3 = 2; raddr_b3 = 3;
        we3 = 1; op3 = 3'd0; waddr3 = 2; wdata3 = 8'hC3;
        cyc();
        chk("d3_load", rdata_a3, 8'hC3);
        waddr3 = 3; wdata3 = 8'h12;
        cyc();
        we3 = 0;
        chk("d3_oor_err",   err3,     1'b1);
        chk("d3_oor_rd",    rdata_b3, 8'h00);
        chk("d3_oor_keep",  rdata_a3, 8'hC3);
        chk("d3_oor_zero",  zero3,    1'b0);
        cyc();
        chk("d3_err_pulse", err3, 1'b0);

        // DEPTH=3: reset during cycle 2 of a sweep
        raddr_a3 = 1;
        we3 = 1; op3 = 3'd7;
        cyc();
        we3 = 0;
        chk("d3_sw_busy", busy3, 1'b1);
        cyc();
        rst = 1;
        cyc();
        rst = 0;
        chk("d3_rst_busy", busy3, 1'b0);
        chk("d3_rst_zero", zero3, 1'b1);
        we3 = 1; op3 = 3'd0; waddr3 = 1; wdata3 = 8'hAB;
        cyc();
        we3 = 0;
        chk("d3_new_load", rdata_a3, 8'hAB);
        chk("d3_new_busy", busy3, 1'b0);
        chk("d3_new_err",  err3,  1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
